rx_packer_param: RTL and testbench
==================================

Name: rx_packer_param

Overview:
Parametrised successor to the fixed 8-to-64 receive concatenator. It packs a narrow MAC-side AXI-Stream (no backpressure) into a wide FIFO-side AXI-Stream with tkeep, tlast and tuser. Additions over the fixed block: configurable widths and lane order, downstream tready backpressure with a one-word output register, and overflow detection with frame discard and a bad-frame terminator. It sits between the MAC receive interface and the RX FIFO in the NIC MAC interface.

Parameters:
IN_W, 8, input beat width in bits.
OUT_W, 64, output word width in bits; must be a multiple of IN_W, with R = OUT_W/IN_W >= 2.
LANE_ORDER, 0, 0 = first beat in the lowest lane (bits IN_W-1:0); 1 = first beat in the highest lane.
CNT_W, 16, width of the dropped-frame counter.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
rx_axis_mac_tdata  in  IN_W  MAC beat data.
rx_axis_mac_tvalid  in  1  beat valid; there is no ready, so every valid beat must be consumed.
rx_axis_mac_tlast  in  1  last beat of frame.
rx_axis_mac_tuser  in  1  frame error; sampled on the tlast beat.
rx_axis_tdata  out  OUT_W  packed word.
rx_axis_tkeep  out  R  lane valid mask.
rx_axis_tvalid  out  1  word valid.
rx_axis_tready  in  1  downstream accept.
rx_axis_tlast  out  1  last word of frame.
rx_axis_tuser  out  1  bad frame; meaningful only when tlast=1.
overflow  out  1  one-cycle pulse when a word is dropped.
drop_cnt  out  CNT_W  saturating count of damaged or lost frames.

Behaviour:
- Reset values: all outputs 0; lane index idx=0; accumulator data and keep 0; state PACK. Reset mid-frame discards the partial word, produces no output, and the next beat packs into the first lane.
- Lane placement: beat k of a word goes to lane k (LANE_ORDER=0) or lane R-1-k (LANE_ORDER=1). Its tkeep bit is set. Unfilled lanes carry data 0 and keep 0.
- Valid gaps between beats are allowed at any point; there is no timeout.
- Completion: a valid beat completes the word when idx==R-1 or tlast=1. If both hold, this is a single completion.
  - On completion: idx<=0, accumulator cleared. The word carries tlast = beat tlast and tuser = beat tlast & beat tuser.
- Output register: "free" means rx_axis_tvalid=0, or rx_axis_tvalid & rx_axis_tready in the same cycle.
  - A completed word loads when the register is free; tvalid rises the cycle after the completing beat (latency 1).
  - tdata, tkeep, tlast and tuser are held stable while tvalid & !tready.
  - tvalid drops after acceptance unless a new word loads in the same cycle, so back-to-back words are allowed.
- State PACK: normal packing as above.
  - Completion while the register is not free: word dropped; overflow=1 for one cycle.
  - If the beat had tlast=1, go to TERM_WAIT. Otherwise go to DISCARD.
- State DISCARD: valid beats are ignored. On a valid tlast beat, go to TERM_WAIT, or load the terminator directly if the register is free that cycle.
- State TERM_WAIT: wait for the register to be free.
  - Then load the terminator (data 0, keep lane-0-equivalent single bit per LANE_ORDER, tlast=1, tuser=1), increment drop_cnt, and go to PACK.
  - drop_cnt also increments when the terminator loads directly from DISCARD.
  - Beats arriving in TERM_WAIT are discarded. A tlast among them increments drop_cnt once more (whole frame lost). The first beat after the terminator loads starts a fresh word.
- drop_cnt saturates at 2^CNT_W-1.
- The accumulator, the output register and the terminator are mutually exclusive sources; only one loads per cycle.

Test Plan:
1. IN_W=8, OUT_W=64, tready=1; frame of 8 bytes 0x01..0x08, gap-free -> one word 0x0807060504030201, keep 0xFF, tlast=1, tuser=0, tvalid the cycle after byte 8.
2. 11-byte frame 0x01..0x0B, tuser=1 on the last byte, random valid gaps -> word 1: keep 0xFF, tlast=0. Word 2: data 0x00000000000B0A09, keep 0x07, tlast=1, tuser=1.
3. 1-byte frame 0xAA -> data 0x..00AA, keep 0x01, tlast=1. Back-to-back with a following 8-byte frame -> no bubble, correct framing.
4. tready=0 for 30 cycles during a 24-byte gap-free frame:
   - word 1 is held stable;
   - byte 16 -> overflow pulse;
   - when tready=1 -> word 1 accepted, then the terminator (keep 0x01, tlast=1, tuser=1);
   - drop_cnt=1;
   - a following frame packs correctly.
5. LANE_ORDER=1: bytes 0x01..0x08 -> 0x0102030405060708. A 3-byte frame -> keep 0xE0, data 0xAABBCC0000000000.
6. Reset pulsed after 5 bytes of a frame -> no output word; the next frame 0x11..0x18 -> 0x1817161514131211, keep 0xFF. drop_cnt stays 0.

Source files
------------

// File: rtl/rx_packer_param.sv
// -----------------------------------------------------------------------------
// rx_packer_param
//
// Packs a narrow MAC-side AXI-Stream (no backpressure) into a wide FIFO-side
// AXI-Stream carrying tkeep, tlast and tuser. Beats are placed into lanes of an
// accumulator; a completed word moves into a one-word output register. When a
// word completes while the output register is still occupied, the rest of that
// frame is discarded and a bad-frame terminator word (data 0, single keep bit,
// tlast=1, tuser=1) is emitted in its place so downstream sees a closed frame.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   rx_axis_mac_tdata  [IN_W]       MAC beat data
//   rx_axis_mac_tvalid              MAC beat valid (must always be consumed)
//   rx_axis_mac_tlast               last beat of frame
//   rx_axis_mac_tuser               frame error, sampled on the tlast beat
//   rx_axis_tdata      [OUT_W]      packed word
//   rx_axis_tkeep      [R]          lane valid mask, R = OUT_W/IN_W
//   rx_axis_tvalid                  word valid
//   rx_axis_tready                  downstream accept
//   rx_axis_tlast                   last word of frame
//   rx_axis_tuser                   bad frame (meaningful when tlast=1)
//   overflow                        one-cycle pulse when a word is dropped
//   drop_cnt           [CNT_W]      saturating count of damaged/lost frames
//   fsm_state          [2]          current FSM state, for observability
//
// Handshake: a word transfers on any rising edge where rx_axis_tvalid and
// rx_axis_tready are both 1. Once tvalid is raised, tdata/tkeep/tlast/tuser
// stay constant until that transfer happens; tvalid never depends on tready.
// The MAC side has no ready: every cycle with rx_axis_mac_tvalid=1 is a beat.
//
// OUT_W must be a multiple of IN_W with OUT_W/IN_W >= 2.
// -----------------------------------------------------------------------------
module rx_packer_param #(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 64,
  parameter int LANE_ORDER = 0,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IN_W-1:0]          rx_axis_mac_tdata,
  input  logic                     rx_axis_mac_tvalid,
  input  logic                     rx_axis_mac_tlast,
  input  logic                     rx_axis_mac_tuser,
  output logic [OUT_W-1:0]         rx_axis_tdata,
  output logic [OUT_W/IN_W-1:0]    rx_axis_tkeep,
  output logic                     rx_axis_tvalid,
  input  logic                     rx_axis_tready,
  output logic                     rx_axis_tlast,
  output logic                     rx_axis_tuser,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [1:0]               fsm_state
);

  localparam int R     = OUT_W / IN_W;
  localparam int IDX_W = $clog2(R);

  // The terminator marks only the lane that the first beat of a word would use.
  localparam logic [R-1:0] TERM_KEEP = (LANE_ORDER != 0) ? {1'b1, {(R-1){1'b0}}}
                                                         : R'(1);

  typedef enum logic [1:0] {
    ST_PACK      = 2'd0,  // normal packing
    ST_DISCARD   = 2'd1,  // dropping the remainder of a damaged frame
    ST_TERM_WAIT = 2'd2   // frame ended, terminator waiting for a free register
  } state_t;

  state_t state_q;
  state_t state_d;

  // Accumulator
  logic [IDX_W-1:0] idx;
  logic [OUT_W-1:0] acc_data;
  logic [R-1:0]     acc_keep;

  // Beat placement
  logic [IDX_W-1:0] lane;
  logic [OUT_W-1:0] beat_word;
  logic [R-1:0]     beat_keep;
  logic [OUT_W-1:0] word_data;
  logic [R-1:0]     word_keep;
  logic             beat_v;
  logic             complete;
  logic             reg_free;

  // FSM decisions
  logic       acc_clear;
  logic       acc_update;
  logic       load_word;
  logic       load_term;
  logic       drop_word;
  logic [1:0] cnt_inc;

  logic [CNT_W:0] cnt_sum;

  assign fsm_state = state_q;

  // ---------------------------------------------------------------------------
  // Datapath: where the current beat lands and what the word would look like
  // if it completed on this beat.
  // ---------------------------------------------------------------------------
  always_comb begin
    lane = idx;
    if (LANE_ORDER != 0) begin
      lane = IDX_W'(R - 1) - idx;
    end
  end

  assign beat_word = {{(OUT_W-IN_W){1'b0}}, rx_axis_mac_tdata} << (int'(lane) * IN_W);
  assign beat_keep = R'(1) << lane;
  assign word_data = acc_data | beat_word;
  assign word_keep = acc_keep | beat_keep;

  assign beat_v   = rx_axis_mac_tvalid;
  // A beat that fills the last lane and also carries tlast is one completion.
  assign complete = beat_v && ((idx == IDX_W'(R - 1)) || rx_axis_mac_tlast);
  // The output register can take a new word this cycle if it is empty or its
  // current word is being accepted on this edge.
  assign reg_free = !rx_axis_tvalid || rx_axis_tready;

  // ---------------------------------------------------------------------------
  // FSM next-state and load decisions. Only one of load_word/load_term can be
  // set in a cycle, so the output register has a single source per edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    acc_clear  = 1'b0;
    acc_update = 1'b0;
    load_word  = 1'b0;
    load_term  = 1'b0;
    drop_word  = 1'b0;
    cnt_inc    = 2'd0;

    case (state_q)
      ST_PACK: begin
        if (complete) begin
          acc_clear = 1'b1;
          if (reg_free) begin
            load_word = 1'b1;
          end else begin
            drop_word = 1'b1;
            state_d   = rx_axis_mac_tlast ? ST_TERM_WAIT : ST_DISCARD;
          end
        end else if (beat_v) begin
          acc_update = 1'b1;
        end
      end

      ST_DISCARD: begin
        if (beat_v && rx_axis_mac_tlast) begin
          if (reg_free) begin
            load_term = 1'b1;
            cnt_inc   = 2'd1;
            state_d   = ST_PACK;
          end else begin
            state_d   = ST_TERM_WAIT;
          end
        end
      end

      ST_TERM_WAIT: begin
        // Beats here are discarded. A frame that ends while we wait was lost
        // in full and is counted on its own, on top of the terminator.
        if (reg_free) begin
          load_term = 1'b1;
          state_d   = ST_PACK;
        end
        cnt_inc = 2'(reg_free) + 2'(beat_v && rx_axis_mac_tlast);
      end

      default: begin
        state_d = ST_PACK;
      end
    endcase
  end

  // Saturating add of up to two events in one cycle.
  assign cnt_sum = {1'b0, drop_cnt} + (CNT_W+1)'(cnt_inc);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_PACK;
      idx            <= '0;
      acc_data       <= '0;
      acc_keep       <= '0;
      rx_axis_tdata  <= '0;
      rx_axis_tkeep  <= '0;
      rx_axis_tvalid <= 1'b0;
      rx_axis_tlast  <= 1'b0;
      rx_axis_tuser  <= 1'b0;
      overflow       <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      state_q  <= state_d;
      overflow <= drop_word;

      if (acc_clear) begin
        idx      <= '0;
        acc_data <= '0;
        acc_keep <= '0;
      end else if (acc_update) begin
        idx      <= idx + 1'b1;
        acc_data <= word_data;
        acc_keep <= word_keep;
      end

      if (load_word) begin
        rx_axis_tdata  <= word_data;
        rx_axis_tkeep  <= word_keep;
        rx_axis_tvalid <= 1'b1;
        rx_axis_tlast  <= rx_axis_mac_tlast;
        rx_axis_tuser  <= rx_axis_mac_tlast & rx_axis_mac_tuser;
      end else if (load_term) begin
        rx_axis_tdata  <= '0;
        rx_axis_tkeep  <= TERM_KEEP;
        rx_axis_tvalid <= 1'b1;
        rx_axis_tlast  <= 1'b1;
        rx_axis_tuser  <= 1'b1;
      end else if (rx_axis_tvalid && rx_axis_tready) begin
        rx_axis_tvalid <= 1'b0;
      end

      if (cnt_sum[CNT_W]) begin
        drop_cnt <= '1;
      end else begin
        drop_cnt <= cnt_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rx_packer_param.sv
// -----------------------------------------------------------------------------
// tb_rx_packer_param
//
// Drives one MAC stream into two instances of rx_packer_param (LANE_ORDER 0
// and LANE_ORDER 1) sharing tready. Expected words are pushed to a queue per
// instance when a frame is driven and popped when a word is accepted.
// -----------------------------------------------------------------------------
module tb_rx_packer_param;

  localparam int IN_W  = 8;
  localparam int OUT_W = 64;
  localparam int R     = OUT_W / IN_W;
  localparam int CNT_W = 16;
  localparam int W     = OUT_W + R + 2;   // {data, keep, last, user}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [IN_W-1:0] mac_tdata;
  logic            mac_tvalid;
  logic            mac_tlast;
  logic            mac_tuser;
  logic            tready;

  logic [OUT_W-1:0] d0_tdata,  d1_tdata;
  logic [R-1:0]     d0_tkeep,  d1_tkeep;
  logic             d0_tvalid, d1_tvalid;
  logic             d0_tlast,  d1_tlast;
  logic             d0_tuser,  d1_tuser;
  logic             d0_ovf,    d1_ovf;
  logic [CNT_W-1:0] d0_cnt,    d1_cnt;
  logic [1:0]       d0_state,  d1_state;

  rx_packer_param #(.IN_W(IN_W), .OUT_W(OUT_W), .LANE_ORDER(0), .CNT_W(CNT_W)) dut0 (
    .clk                (clk),
    .reset              (reset),
    .rx_axis_mac_tdata  (mac_tdata),
    .rx_axis_mac_tvalid (mac_tvalid),
    .rx_axis_mac_tlast  (mac_tlast),
    .rx_axis_mac_tuser  (mac_tuser),
    .rx_axis_tdata      (d0_tdata),
    .rx_axis_tkeep      (d0_tkeep),
    .rx_axis_tvalid     (d0_tvalid),
    .rx_axis_tready     (tready),
    .rx_axis_tlast      (d0_tlast),
    .rx_axis_tuser      (d0_tuser),
    .overflow           (d0_ovf),
    .drop_cnt           (d0_cnt),
    .fsm_state          (d0_state)
  );

  rx_packer_param #(.IN_W(IN_W), .OUT_W(OUT_W), .LANE_ORDER(1), .CNT_W(CNT_W)) dut1 (
    .clk                (clk),
    .reset              (reset),
    .rx_axis_mac_tdata  (mac_tdata),
    .rx_axis_mac_tvalid (mac_tvalid),
    .rx_axis_mac_tlast  (mac_tlast),
    .rx_axis_mac_tuser  (mac_tuser),
    .rx_axis_tdata      (d1_tdata),
    .rx_axis_tkeep      (d1_tkeep),
    .rx_axis_tvalid     (d1_tvalid),
    .rx_axis_tready     (tready),
    .rx_axis_tlast      (d1_tlast),
    .rx_axis_tuser      (d1_tuser),
    .overflow           (d1_ovf),
    .drop_cnt           (d1_cnt),
    .fsm_state          (d1_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [7:0]   frm[$];
  int checks = 0;
  int errors = 0;
  int ovf_cnt0 = 0;
  int ovf_cnt1 = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1, return at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    mac_tdata  = d;
    mac_tvalid = 1'b1;
    mac_tlast  = l;
    mac_tuser  = u;
    @(posedge clk); #1;
    mac_tvalid = 1'b0;
    mac_tlast  = 1'b0;
    mac_tuser  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives frm[] as one frame; tuser goes with the tlast beat.
  task automatic send_frame(input int gap_max, input logic user);
    for (int i = 0; i < frm.size(); i++) begin
      send_beat(frm[i], i == frm.size() - 1, (i == frm.size() - 1) && user);
      if (gap_max > 0 && i != frm.size() - 1) idle($urandom_range(0, gap_max));
    end
  endtask

  // Reference packing of frm[] for both lane orders.
  task automatic push_model(input logic user);
    int n;
    logic [63:0] dl, dh;
    logic [7:0]  kl, kh;
    logic        lst;
    n = frm.size();
    for (int c = 0; c < n; c += R) begin
      dl = '0; dh = '0; kl = '0; kh = '0;
      for (int k = 0; k < R; k++) begin
        if (c + k < n) begin
          dl[8*k +: 8]       = frm[c+k];
          kl[k]              = 1'b1;
          dh[8*(R-1-k) +: 8] = frm[c+k];
          kh[R-1-k]          = 1'b1;
        end
      end
      lst = (c + R >= n);
      exp_q0.push_back({dl, kl, lst, lst & user});
      exp_q1.push_back({dh, kh, lst, lst & user});
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || d0_tvalid || d1_tvalid) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_q0_left", 128'(exp_q0.size()), 128'd0);
    check("drain_q1_left", 128'(exp_q1.size()), 128'd0);
    check("drain_d0_tvalid", 128'(d0_tvalid), 128'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pop on acceptance, compare the held word while stalled
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset) begin
      if (d0_ovf) ovf_cnt0++;
      if (d1_ovf) ovf_cnt1++;
      if (d0_tvalid) begin
        check("d0_word_expected", 128'(exp_q0.size() != 0), 128'd1);
        if (exp_q0.size() != 0) begin
          if (tready) check("d0_word", 128'({d0_tdata, d0_tkeep, d0_tlast, d0_tuser}), 128'(exp_q0.pop_front()));
          else        check("d0_hold", 128'({d0_tdata, d0_tkeep, d0_tlast, d0_tuser}), 128'(exp_q0[0]));
        end
      end
      if (d1_tvalid) begin
        check("d1_word_expected", 128'(exp_q1.size() != 0), 128'd1);
        if (exp_q1.size() != 0) begin
          if (tready) check("d1_word", 128'({d1_tdata, d1_tkeep, d1_tlast, d1_tuser}), 128'(exp_q1.pop_front()));
          else        check("d1_hold", 128'({d1_tdata, d1_tkeep, d1_tlast, d1_tuser}), 128'(exp_q1[0]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    mac_tdata  = '0;
    mac_tvalid = 1'b0;
    mac_tlast  = 1'b0;
    mac_tuser  = 1'b0;
    tready     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_d0_outputs", 128'({d0_tdata, d0_tkeep, d0_tvalid, d0_tlast, d0_tuser, d0_ovf}), 128'd0);
    check("rst_d1_outputs", 128'({d1_tdata, d1_tkeep, d1_tvalid, d1_tlast, d1_tuser, d1_ovf}), 128'd0);
    check("rst_d0_cnt_state", 128'({d0_cnt, d0_state}), 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1) Eight gap-free bytes, one full word, latency 1.
    exp_q0.push_back({64'h0807060504030201, 8'hFF, 1'b1, 1'b0});
    exp_q1.push_back({64'h0102030405060708, 8'hFF, 1'b1, 1'b0});
    for (int i = 1; i <= 7; i++) send_beat(8'(i), 1'b0, 1'b0);
    check("t1_no_early_valid", 128'(d0_tvalid), 128'd0);
    send_beat(8'h08, 1'b1, 1'b0);
    check("t1_latency_d0", 128'(d0_tvalid), 128'd1);
    check("t1_latency_d1", 128'(d1_tvalid), 128'd1);
    wait_drain(20);

    // 2) Eleven bytes with random gaps, tuser on the last beat.
    frm = {};
    for (int i = 1; i <= 11; i++) frm.push_back(8'(i));
    exp_q0.push_back({64'h0807060504030201, 8'hFF, 1'b0, 1'b0});
    exp_q0.push_back({64'h00000000000B0A09, 8'h07, 1'b1, 1'b1});
    exp_q1.push_back({64'h0102030405060708, 8'hFF, 1'b0, 1'b0});
    exp_q1.push_back({64'h090A0B0000000000, 8'hE0, 1'b1, 1'b1});
    send_frame(3, 1'b1);
    wait_drain(20);

    // 3) One-byte frame back-to-back with an eight-byte frame.
    frm = {8'hAA};
    push_model(1'b0);
    send_frame(0, 1'b0);
    frm = {};
    for (int i = 0; i < 8; i++) frm.push_back(8'h41 + 8'(i));
    push_model(1'b0);
    send_frame(0, 1'b0);
    wait_drain(20);

    // 5) Short frame exercising the lane-order difference.
    exp_q0.push_back({64'h0000000000CCBBAA, 8'h07, 1'b1, 1'b0});
    exp_q1.push_back({64'hAABBCC0000000000, 8'hE0, 1'b1, 1'b0});
    frm = {8'hAA, 8'hBB, 8'hCC};
    send_frame(0, 1'b0);
    wait_drain(20);
    check("t5_d0_drop_cnt", 128'(d0_cnt), 128'd0);
    check("t5_ovf_none", 128'(ovf_cnt0 + ovf_cnt1), 128'd0);

    // 4) Stall for 30 cycles during a 24-byte frame: overflow and terminator.
    tready = 1'b0;
    frm = {};
    for (int i = 1; i <= 24; i++) frm.push_back(8'h20 + 8'(i));
    exp_q0.push_back({64'h2827262524232221, 8'hFF, 1'b0, 1'b0});
    exp_q0.push_back({64'h0, 8'h01, 1'b1, 1'b1});
    exp_q1.push_back({64'h2122232425262728, 8'hFF, 1'b0, 1'b0});
    exp_q1.push_back({64'h0, 8'h80, 1'b1, 1'b1});
    send_frame(0, 1'b0);
    idle(6);
    check("t4_cnt_before_term", 128'(d0_cnt), 128'd0);
    check("t4_d0_term_wait", 128'(d0_state), 128'd2);
    check("t4_d0_ovf_pulses", 128'(ovf_cnt0), 128'd1);
    check("t4_d1_ovf_pulses", 128'(ovf_cnt1), 128'd1);
    tready = 1'b1;
    wait_drain(20);
    check("t4_d0_drop_cnt", 128'(d0_cnt), 128'd1);
    check("t4_d1_drop_cnt", 128'(d1_cnt), 128'd1);
    check("t4_d0_back_to_pack", 128'(d0_state), 128'd0);
    frm = {};
    for (int i = 0; i < 10; i++) frm.push_back(8'h31 + 8'(i));
    push_model(1'b0);
    send_frame(2, 1'b0);
    wait_drain(40);
    check("t4_ovf_after", 128'(ovf_cnt0), 128'd1);

    // 6) Reset in the middle of a frame, then a clean frame.
    for (int i = 0; i < 5; i++) send_beat(8'h51 + 8'(i), 1'b0, 1'b0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("t6_d0_after_reset", 128'({d0_tvalid, d0_cnt, d0_state}), 128'd0);
    check("t6_d1_after_reset", 128'({d1_tvalid, d1_cnt, d1_state}), 128'd0);
    exp_q0.push_back({64'h1817161514131211, 8'hFF, 1'b1, 1'b0});
    exp_q1.push_back({64'h1112131415161718, 8'hFF, 1'b1, 1'b0});
    frm = {};
    for (int i = 0; i < 8; i++) frm.push_back(8'h11 + 8'(i));
    send_frame(0, 1'b0);
    wait_drain(20);
    check("t6_d0_drop_cnt", 128'(d0_cnt), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
